// File: rtl/uparc_muldiv_hilo_pkg.sv
// Shared constants for the mult/div issue unit: op codes, FSM states, counter sizing.
package uparc_muldiv_hilo_pkg;

  localparam int REG_WIDTH = 32;
  localparam int CNT_W     = 6;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIV_START = 2'd1,
    ST_DIV_WAIT  = 2'd2,
    ST_MUL_RUN   = 2'd3
  } md_state_t;

endpackage

// File: rtl/uparc_muldiv_hilo_if.sv
// Execute-stage request/response bundle for the mult/div unit and HI/LO readout.
interface uparc_muldiv_hilo_if #(
  parameter int W = 32
);
  logic         op_valid;
  logic [2:0]   op_code;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_ready;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output op_valid, op_code, op_a, op_b,
    input  op_ready, busy, hi, lo
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b,
    output op_ready, busy, hi, lo
  );
endinterface

// File: rtl/uparc_long_imul.sv
// Iterative shift-add multiplier: one bit per cycle on operand magnitudes, sign applied at the end.
module uparc_long_imul
  import uparc_muldiv_hilo_pkg::*;
#(
  parameter int W = REG_WIDTH
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           start,
  input  logic           signd,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           ready,
  output logic [2*W-1:0] prod
);

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     mcand;
  logic [2*W-1:0]   acc;
  logic             neg;
  logic [W:0]       sum;
  logic [2*W-1:0]   acc_nxt;

  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
    logic signed [W-1:0] sv;
    sv = v;
    if (sgn && sv < 0)
      return -sv;
    return v;
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      cnt <= '0;
    else if (start)
      cnt <= CNT_W'(W);
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand <= mag(a, signd);
      acc   <= {{W{1'b0}}, mag(b, signd)};
      neg   <= signd && (a[W-1] ^ b[W-1]);
    end else if (cnt != '0) begin
      acc   <= acc_nxt;
    end
  end

  // Upper half accumulates the multiplicand while the multiplier drains out of the lower half.
  always_comb begin
    sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    acc_nxt = {sum, acc[W-1:1]};
  end

  // Ready marks the final step; the product of that step is presented combinationally.
  assign ready = (cnt == CNT_W'(1));
  assign prod  = neg ? -acc_nxt : acc_nxt;

endmodule

// File: rtl/uparc_muldiv_hilo.sv
// Mult/div issue unit with architectural HI/LO; drives an external divider and the local multiplier.
module uparc_muldiv_hilo
  import uparc_muldiv_hilo_pkg::*;
#(
  parameter int W = REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  uparc_muldiv_hilo_if.slave    op,
  output logic                  div_start,
  output logic                  div_signd,
  output logic [W-1:0]          div_dividend,
  output logic [W-1:0]          div_divider,
  input  logic                  div_ready,
  input  logic [2*W-1:0]        div_remquot
);

  md_state_t      state;
  md_state_t      state_nxt;
  logic [W-1:0]   hi_reg;
  logic [W-1:0]   lo_reg;
  logic           accept;
  logic           op_is_div;
  logic           op_is_mul;
  logic           div_go;
  logic           mul_start;
  logic           mul_ready;
  logic [2*W-1:0] mul_prod;

  assign accept    = op.op_valid && (state == ST_IDLE);
  assign op_is_div = (op.op_code == MD_DIV)  || (op.op_code == MD_DIVU);
  assign op_is_mul = (op.op_code == MD_MULT) || (op.op_code == MD_MULTU);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_go    = 1'b0;
    mul_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && op_is_div) begin
          state_nxt = ST_DIV_START;
          div_go    = 1'b1;
        end else if (accept && op_is_mul) begin
          state_nxt = ST_MUL_RUN;
          mul_start = 1'b1;
        end
      end
      // Divider still sees start this cycle, so its ready is not meaningful yet.
      ST_DIV_START: state_nxt = ST_DIV_WAIT;
      ST_DIV_WAIT:  if (div_ready) state_nxt = ST_IDLE;
      ST_MUL_RUN:   if (mul_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Divider operands persist after completion: the divider's sign fix-up reads them combinationally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_start    <= 1'b0;
      div_signd    <= 1'b0;
      div_dividend <= '0;
      div_divider  <= '0;
    end else begin
      div_start <= div_go;
      if (div_go) begin
        div_signd    <= (op.op_code == MD_DIV);
        div_dividend <= op.op_a;
        div_divider  <= op.op_b;
      end
      if (accept && op.op_code == MD_MTHI)
        hi_reg <= op.op_a;
      if (accept && op.op_code == MD_MTLO)
        lo_reg <= op.op_a;
      if (state == ST_DIV_WAIT && div_ready)
        {hi_reg, lo_reg} <= div_remquot;
      if (state == ST_MUL_RUN && mul_ready)
        {hi_reg, lo_reg} <= mul_prod;
    end
  end

  uparc_long_imul #(.W(W)) u_imul (
    .clk   (clk),
    .nrst  (nrst),
    .start (mul_start),
    .signd (op.op_code == MD_MULT),
    .a     (op.op_a),
    .b     (op.op_b),
    .ready (mul_ready),
    .prod  (mul_prod)
  );

  assign op.busy     = (state != ST_IDLE);
  assign op.op_ready = (state == ST_IDLE);
  assign op.hi       = hi_reg;
  assign op.lo       = lo_reg;

endmodule

// File: tb/tb_uparc_muldiv_hilo.sv
// Directed scoreboard bench for uparc_muldiv_hilo with a cycle-timed behavioural divider attached.
module tb_uparc_muldiv_hilo;
  import uparc_muldiv_hilo_pkg::*;

  localparam int W = 32;

  logic clk;
  logic nrst;
  logic div_start, div_signd, div_ready;
  logic [W-1:0] div_dividend, div_divider;
  logic [2*W-1:0] div_remquot;

  uparc_muldiv_hilo_if #(.W(W)) ifc ();

  uparc_muldiv_hilo #(.W(W)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .op           (ifc.slave),
    .div_start    (div_start),
    .div_signd    (div_signd),
    .div_dividend (div_dividend),
    .div_divider  (div_divider),
    .div_ready    (div_ready),
    .div_remquot  (div_remquot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: 32 iterations after start, immediate finish when either operand is zero.
  logic [5:0] nbit;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      nbit <= '0;
    else if (div_start)
      nbit <= (div_dividend == 0 || div_divider == 0) ? 6'd0 : 6'd32;
    else if (nbit != 0)
      nbit <= nbit - 6'd1;
  end
  assign div_ready = (nbit == 0) && !div_start;

  logic [W-1:0] ma, mb, mq, mr;
  always_comb begin
    ma = (div_signd && div_dividend[W-1]) ? -div_dividend : div_dividend;
    mb = (div_signd && div_divider[W-1])  ? -div_divider  : div_divider;
    mq = '0;
    mr = '0;
    if (ma != 0 && mb != 0) begin
      mq = ma / mb;
      mr = ma % mb;
      if (div_signd && (div_dividend[W-1] ^ div_divider[W-1])) mq = -mq;
      if (div_signd && div_dividend[W-1]) mr = -mr;
    end
    div_remquot = {mr, mq};
  end

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           vis;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns one time step after the acceptance edge.
  task automatic drive_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int waited);
    ifc.op_valid = 1'b1;
    ifc.op_code  = code;
    ifc.op_a     = a;
    ifc.op_b     = b;
    waited = 0;
    while (!ifc.op_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ifc.op_ready) chk("accept_timeout", {63'd0, ifc.op_ready}, 64'd1);
    @(posedge clk);
    #1;
    ifc.op_valid = 1'b0;
    ifc.op_code  = MD_NOP;
  endtask

  task automatic issue(input string tag, input logic [2:0] code, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int vis);
    int w;
    exp_t e;
    @(negedge clk);
    drive_op(code, a, b, w);
    e.hi = eh;
    e.lo = el;
    e.vis = vis;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic wait_done(output int ds_cnt, output int ds_cyc);
    int k;
    exp_t e;
    string t;
    k = 1;
    ds_cnt = 0;
    ds_cyc = 0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        ds_cnt++;
        ds_cyc = k;
      end
      if (!ifc.busy || k >= 200) break;
      k++;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_cycle"}, 64'(k), 64'(e.vis));
    chk({t, "_hi"}, 64'(ifc.hi), 64'(e.hi));
    chk({t, "_lo"}, 64'(ifc.lo), 64'(e.lo));
  endtask

  initial begin
    int dc, dy, w;
    nrst = 1'b0;
    ifc.op_valid = 1'b0;
    ifc.op_code  = MD_NOP;
    ifc.op_a     = '0;
    ifc.op_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(ifc.hi), 64'd0);
    chk("rst_lo", 64'(ifc.lo), 64'd0);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_ready", 64'(ifc.op_ready), 64'd1);
    chk("rst_div_start", 64'(div_start), 64'd0);
    chk("rst_div_signd", 64'(div_signd), 64'd0);
    chk("rst_dividend", 64'(div_dividend), 64'd0);
    chk("rst_divider", 64'(div_divider), 64'd0);
    nrst = 1'b1;

    // MTHI then MTLO back-to-back, each visible the cycle after its acceptance edge.
    @(negedge clk);
    drive_op(MD_MTHI, 32'h1234, 32'h0, w);
    @(negedge clk);
    chk("mthi_hi_c1", 64'(ifc.hi), 64'h1234);
    chk("mthi_busy_c1", 64'(ifc.busy), 64'd0);
    drive_op(MD_MTLO, 32'h5678, 32'h0, w);
    @(negedge clk);
    chk("mtlo_lo_c1", 64'(ifc.lo), 64'h5678);
    chk("mtlo_hi_keep", 64'(ifc.hi), 64'h1234);
    chk("mtlo_busy_c1", 64'(ifc.busy), 64'd0);

    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 35);
    wait_done(dc, dy);
    chk("divu_start_cnt", 64'(dc), 64'd1);
    chk("divu_start_cyc", 64'(dy), 64'd1);
    chk("divu_dividend_hold", 64'(div_dividend), 64'd100);
    chk("divu_divider_hold", 64'(div_divider), 64'd7);
    chk("divu_signd", 64'(div_signd), 64'd0);

    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35);
    wait_done(dc, dy);
    chk("div_signd", 64'(div_signd), 64'd1);

    issue("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 35);
    wait_done(dc, dy);

    issue("div_5_0", MD_DIV, 32'd5, 32'd0, 32'h0, 32'h0, 3);
    wait_done(dc, dy);

    issue("mthi_77", MD_MTHI, 32'h77, 32'h0, 32'h77, 32'h0, 1);
    wait_done(dc, dy);

    issue("divu_0_9", MD_DIVU, 32'd0, 32'd9, 32'h0, 32'h0, 3);
    wait_done(dc, dy);
    chk("divu0_start_cnt", 64'(dc), 64'd1);

    issue("mult_m1_2", MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    wait_done(dc, dy);
    chk("mult_no_div_start", 64'(dc), 64'd0);
    chk("mult_dividend_hold", 64'(div_dividend), 64'd0);
    chk("mult_divider_hold", 64'(div_divider), 64'd9);

    issue("multu_ff_2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 33);
    wait_done(dc, dy);

    issue("mult_min_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33);
    wait_done(dc, dy);

    issue("nop", MD_NOP, 32'h1111, 32'h2222, 32'h4000_0000, 32'h0, 1);
    wait_done(dc, dy);
    issue("reserved", 3'd7, 32'h3333, 32'h4444, 32'h4000_0000, 32'h0, 1);
    wait_done(dc, dy);

    // MTLO presented during a MULT is held off, then overwrites the product's low half.
    @(negedge clk);
    drive_op(MD_MULT, 32'hFFFF_0000, 32'h0001_0000, w);
    @(negedge clk);
    drive_op(MD_MTLO, 32'hABCD, 32'h0, w);
    chk("mtlo_held_cycles", 64'(w), 64'd32);
    @(negedge clk);
    chk("mul_mtlo_hi", 64'(ifc.hi), 64'hFFFF_FFFF);
    chk("mul_mtlo_lo", 64'(ifc.lo), 64'hABCD);
    chk("mul_mtlo_busy", 64'(ifc.busy), 64'd0);

    // Asynchronous reset in the middle of a divide.
    drive_op(MD_DIV, 32'd100, 32'd7, w);
    repeat (10) @(negedge clk);
    chk("abort_busy_before", 64'(ifc.busy), 64'd1);
    nrst = 1'b0;
    #1;
    chk("abort_hi", 64'(ifc.hi), 64'd0);
    chk("abort_lo", 64'(ifc.lo), 64'd0);
    chk("abort_busy", 64'(ifc.busy), 64'd0);
    chk("abort_div_start", 64'(div_start), 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    issue("divu_9_3", MD_DIVU, 32'd9, 32'd3, 32'h0, 32'h3, 35);
    wait_done(dc, dy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
